// File: rtl/s_instr_encoder.sv
// s_instr_encoder
//
// Packs RISC-V store fields (offset, rs2, rs1, funct3) into a 32-bit S-type
// instruction word and emits it through a 2-entry valid/ready buffer. Each
// emitted word carries a word-aligned address from an internal counter.
//
// Optional feature macro: S_ENC_RANGE_CHECK_EN
//   defined   : offsets outside -2048..2047 are consumed and dropped (err_pulse)
//   undefined : offset is silently truncated to offset[11:0]
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of buffer and address counter
//   in_valid/in_ready   input field-set handshake
//   offset, rs2, rs1    store fields (offset is a signed byte offset)
//   funct3              0=SB, 1=SH, 2=SW; 3..7 illegal
//   out_valid/out_ready output word handshake
//   instr_word          encoded instruction at the buffer head
//   instr_addr          address tag of instr_word
//   err_pulse           one-cycle pulse after a consumed-but-dropped input
//   word_count          saturating count of emitted words
module s_instr_encoder #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       offset,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rs1,
  input  logic [2:0]        funct3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr_word,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              err_pulse,
  output logic [15:0]       word_count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e            state_q;
  logic [31:0]       headWord_q;
  logic [31:0]       tailWord_q;
  logic [ADDR_W-1:0] headAddr_q;
  logic [ADDR_W-1:0] tailAddr_q;
  logic [ADDR_W-1:0] nextAddr_q;
  logic [ADDR_W-1:0] nextAddr_d;
  logic              errPulse_q;
  logic [15:0]       wordCount_q;
  logic [15:0]       wordCount_d;

  logic              rangeOk;
  logic              fieldsOk;
  logic              accept;
  logic              push;
  logic              pop;
  logic [31:0]       encWord;

`ifdef S_ENC_RANGE_CHECK_EN
  // A 12-bit signed immediate fits only when bits 31..11 are a pure sign extension.
  assign rangeOk = (offset[31:11] == '0) || (offset[31:11] == '1);
`else
  logic unusedOffsetHi;
  assign rangeOk        = 1'b1;
  assign unusedOffsetHi = ^offset[31:12];
`endif

  // Handshake readiness depends on buffer state only, so there is no
  // combinational path from any input to in_ready/out_valid.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);

  // flush wins over both handshakes: a same-cycle accept or pop is ignored.
  assign fieldsOk = (funct3 <= 3'd2) && rangeOk;
  assign accept   = in_valid && in_ready && !flush;
  assign push     = accept && fieldsOk;
  assign pop      = out_valid && out_ready && !flush;

  assign encWord = {offset[11:5], rs2, rs1, funct3, offset[4:0], OPCODE_STORE};

  assign nextAddr_d  = nextAddr_q + ADDR_W'(4);
  assign wordCount_d = (wordCount_q == 16'hFFFF) ? wordCount_q : wordCount_q + 16'd1;

  assign instr_word = headWord_q;
  assign instr_addr = headAddr_q;
  assign err_pulse  = errPulse_q;
  assign word_count = wordCount_q;

  // Buffer FSM. The head registers are left untouched when the buffer
  // empties, which keeps the last popped word on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      headWord_q  <= '0;
      tailWord_q  <= '0;
      headAddr_q  <= '0;
      tailAddr_q  <= '0;
      nextAddr_q  <= BASE;
      errPulse_q  <= 1'b0;
      wordCount_q <= '0;
    end else begin
      errPulse_q <= accept && !fieldsOk;
      if (pop) begin
        wordCount_q <= wordCount_d;
      end
      if (flush) begin
        state_q    <= EMPTY;
        nextAddr_q <= BASE;
      end else begin
        if (push) begin
          nextAddr_q <= nextAddr_d;
        end
        case (state_q)
          EMPTY: begin
            if (push) begin
              headWord_q <= encWord;
              headAddr_q <= nextAddr_q;
              state_q    <= ONE;
            end
          end
          ONE: begin
            if (push && pop) begin
              headWord_q <= encWord;
              headAddr_q <= nextAddr_q;
            end else if (push) begin
              tailWord_q <= encWord;
              tailAddr_q <= nextAddr_q;
              state_q    <= TWO;
            end else if (pop) begin
              state_q <= EMPTY;
            end
          end
          TWO: begin
            if (pop) begin
              headWord_q <= tailWord_q;
              headAddr_q <= tailAddr_q;
              state_q    <= ONE;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_s_instr_encoder.sv
// tb_s_instr_encoder
//
// Scoreboard bench for s_instr_encoder. A reference model sitting on the
// clock edge pushes the expected word/address for every legal field set the
// encoder takes, and pops on every output handshake. A monitor on the falling
// edge compares the DUT outputs against the model's view of the buffer.
// Directed scenarios follow the basic, negative-offset, backpressure, illegal,
// flush and range cases, then a randomized run and a mid-transfer reset.
module tb_s_instr_encoder;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       offset = '0;
  logic [4:0]        rs2 = '0;
  logic [4:0]        rs1 = '0;
  logic [2:0]        funct3 = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       instr_word;
  logic [ADDR_W-1:0] instr_addr;
  logic              err_pulse;
  logic [15:0]       word_count;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  s_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .offset     (offset),
    .rs2        (rs2),
    .rs1        (rs1),
    .funct3     (funct3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr_word (instr_word),
    .instr_addr (instr_addr),
    .err_pulse  (err_pulse),
    .word_count (word_count)
  );

  // Reference model: S-type layout computed with plain arithmetic.
  function automatic logic [31:0] encodeRef(input logic [31:0] off, input logic [4:0] r2,
                                            input logic [4:0] r1, input logic [2:0] f3);
    logic [31:0] imm;
    imm = off % 32'd4096;
    return ((imm / 32'd32) << 25) + (32'(r2) << 20) + (32'(r1) << 15)
         + (32'(f3) << 12) + ((imm % 32'd32) << 7) + 32'h23;
  endfunction

  function automatic bit inRangeRef(input logic [31:0] off);
`ifdef S_ENC_RANGE_CHECK_EN
    int signed s;
    s = $signed(off);
    return (s >= -2048) && (s <= 2047);
`else
    return 1'b1;
`endif
  endfunction

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } entry_t;

  entry_t      expQ[$];
  entry_t      poppedEntry;
  logic [31:0] mNextAddr = BASE;
  logic        mErr = 1'b0;
  logic [15:0] mCount = '0;
  logic [31:0] mLastWord = '0;
  logic [31:0] mLastAddr = '0;
  bit          mHoldKnown = 1'b1;
  bit          mPop;
  bit          mAcc;
  bit          mLegal;

  // Model update: inputs are stable at the rising edge, so the model sees the
  // same handshake the DUT samples; occupancy comes from the model queue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expQ.delete();
      mNextAddr  = BASE;
      mErr       = 1'b0;
      mCount     = '0;
      mLastWord  = '0;
      mLastAddr  = '0;
      mHoldKnown = 1'b1;
    end else if (flush) begin
      expQ.delete();
      mNextAddr  = BASE;
      mErr       = 1'b0;
      mHoldKnown = 1'b0;
    end else begin
      mPop   = (expQ.size() > 0) && out_ready;
      mAcc   = in_valid && (expQ.size() < 2);
      mLegal = (funct3 < 3'd3) && inRangeRef(offset);
      if (mPop) begin
        poppedEntry = expQ.pop_front();
        mLastWord   = poppedEntry.word;
        mLastAddr   = poppedEntry.addr;
        mHoldKnown  = 1'b1;
        if (mCount != 16'hFFFF) mCount = mCount + 16'd1;
      end
      if (mAcc && mLegal) begin
        expQ.push_back('{word: encodeRef(offset, rs2, rs1, funct3), addr: mNextAddr});
        mNextAddr = mNextAddr + 32'd4;
      end
      mErr = mAcc && !mLegal;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: compares every output against the model on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("in_ready", 32'(in_ready), 32'(expQ.size() < 2));
      checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() != 0));
      checkOutput("err_pulse", 32'(err_pulse), 32'(mErr));
      checkOutput("word_count", 32'(word_count), 32'(mCount));
      if (expQ.size() != 0) begin
        checkOutput("instr_word", instr_word, expQ[0].word);
        checkOutput("instr_addr", 32'(instr_addr), expQ[0].addr);
      end else if (mHoldKnown) begin
        checkOutput("hold_word", instr_word, mLastWord);
        checkOutput("hold_addr", 32'(instr_addr), mLastAddr);
      end
    end
  end

  // Presents a field set (called at rising edge + 1) and returns at rising
  // edge + 1 right after it is accepted, with in_valid still high.
  task automatic applyStimulus(input logic [31:0] off, input logic [4:0] r2,
                               input logic [4:0] r1, input logic [2:0] f3);
    bit taken;
    taken    = 1'b0;
    in_valid = 1'b1;
    offset   = off;
    rs2      = r2;
    rs1      = r1;
    funct3   = f3;
    for (int c = 0; c < 60 && !taken; c++) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
    end
    if (!taken) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1 within 60 cycles");
      in_valid = 1'b0;
    end
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    // Reset values.
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_instr_word", instr_word, 32'd0);
    checkOutput("rst_instr_addr", 32'(instr_addr), 32'd0);
    checkOutput("rst_err_pulse", 32'(err_pulse), 32'd0);
    checkOutput("rst_word_count", 32'(word_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleCycles(1);

    // Basic encode.
    out_ready = 1'b1;
    applyStimulus(32'd8, 5'd5, 5'd2, 3'd2);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("basic_word", instr_word, 32'h00512423);
    checkOutput("basic_addr", 32'(instr_addr), 32'd0);
    checkOutput("basic_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("basic_count", 32'(word_count), 32'd1);

    // Negative offset, second word after reset gets address 4.
    @(posedge clk);
    #1;
    applyStimulus(32'hFFFF_FFFF, 5'd1, 5'd3, 3'd0);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("neg_word", instr_word, 32'hFE118FA3);
    checkOutput("neg_addr", 32'(instr_addr), 32'd4);
    @(posedge clk);
    #1;
    idleCycles(2);

    // Backpressure: third input held until the consumer drains.
    out_ready = 1'b0;
    pulseFlush();
    applyStimulus(32'd16, 5'd6, 5'd7, 3'd2);
    applyStimulus(32'd20, 5'd8, 5'd9, 3'd1);
    fork
      applyStimulus(32'd24, 5'd10, 5'd11, 3'd0);
      begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
          checkOutput("bp_hold_addr", 32'(instr_addr), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    idleCycles(4);

    // Illegal funct3 between two stores: no address gap.
    pulseFlush();
    applyStimulus(32'd4, 5'd1, 5'd2, 3'd2);
    applyStimulus(32'd4, 5'd1, 5'd2, 3'd3);
    fork
      applyStimulus(32'd12, 5'd3, 5'd4, 3'd2);
      begin
        @(negedge clk);
        checkOutput("illegal_err", 32'(err_pulse), 32'd1);
      end
    join
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("illegal_next_addr", 32'(instr_addr), 32'd4);
    @(posedge clk);
    #1;
    idleCycles(2);

    // Flush with two buffered words, then flush racing an accept.
    out_ready = 1'b0;
    applyStimulus(32'd32, 5'd1, 5'd1, 3'd2);
    applyStimulus(32'd36, 5'd2, 5'd2, 3'd2);
    in_valid = 1'b0;
    pulseFlush();
    @(negedge clk);
    checkOutput("flush_two_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(32'd40, 5'd3, 5'd3, 3'd2);
    flush = 1'b1;
    applyStimulus(32'd44, 5'd4, 5'd4, 3'd2);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_acc_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(32'd48, 5'd5, 5'd5, 3'd2);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_base_addr", 32'(instr_addr), BASE);
    @(posedge clk);
    #1;
    idleCycles(2);

    // Offset 2048: outside the 12-bit signed range.
    applyStimulus(32'd2048, 5'd1, 5'd2, 3'd2);
    in_valid = 1'b0;
    @(negedge clk);
`ifdef S_ENC_RANGE_CHECK_EN
    checkOutput("range_err", 32'(err_pulse), 32'd1);
    checkOutput("range_valid", 32'(out_valid), 32'd0);
`else
    checkOutput("range_imm_hi", 32'(instr_word[31:25]), 32'h40);
    checkOutput("range_valid", 32'(out_valid), 32'd1);
`endif
    @(posedge clk);
    #1;
    idleCycles(2);

    // Randomized traffic; the monitor and model do all the checking.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      offset    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom_range(0, 4095) - 32'd2048);
      funct3    = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      rs2       = 5'($urandom);
      rs1       = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    flush     = 1'b0;
    out_ready = 1'b1;
    idleCycles(4);

    // Reset mid-transfer drops buffered words immediately.
    out_ready = 1'b0;
    applyStimulus(32'd8, 5'd9, 5'd10, 3'd2);
    applyStimulus(32'd12, 5'd11, 5'd12, 3'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_word", instr_word, 32'd0);
    checkOutput("midrst_count", 32'(word_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(32'd100, 5'd13, 5'd14, 3'd0);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("midrst_addr", 32'(instr_addr), BASE);
    @(posedge clk);
    #1;
    idleCycles(3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/s_instr_encoder.md
Name: s_instr_encoder

Overview:
- Inverse of the S-type field decoder: packs store-instruction fields (imm, rs2, rs1, funct3) into a 32-bit RISC-V S-type instruction word.
- Sits between a test-program generator (or self-loader) and instruction memory.
- Input side: valid/ready. Output side: 2-entry buffered valid/ready stream, each word tagged with a word-aligned address from an internal counter.

Parameters:
- ADDR_W, 32, width of the output address counter.
- BASE_ADDR, 32'h0000_0000, address loaded into the counter at reset and on flush; must be 4-byte aligned.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of buffer and address counter.
- in_valid  input  1  field set present.
- in_ready  output  1  encoder can accept a field set this cycle.
- offset  input  32  signed byte offset (two's complement).
- rs2  input  5  source (data) register.
- rs1  input  5  base register.
- funct3  input  3  0=SB, 1=SH, 2=SW; 3..7 illegal.
- out_valid  output  1  instr_word/instr_addr valid.
- out_ready  input  1  consumer accepts word.
- instr_word  output  32  encoded instruction.
- instr_addr  output  ADDR_W  address tag of instr_word.
- err_pulse  output  1  one-cycle pulse when an input was consumed and dropped.
- word_count  output  16  total words emitted (saturating).

Behaviour:
- Reset (async, rst_n=0):
  - Buffer empty; state EMPTY.
  - out_valid=0, instr_word=0, instr_addr=0, err_pulse=0, word_count=0.
  - in_ready=1 once reset releases.
  - Internal next-address counter = BASE_ADDR.
- Encoding uses imm = offset[11:0]:
  - instr[31:25]=imm[11:5]
  - instr[24:20]=rs2
  - instr[19:15]=rs1
  - instr[14:12]=funct3
  - instr[11:7]=imm[4:0]
  - instr[6:0]=7'b0100011
- Input accept: in_valid && in_ready at a rising edge.
- Legal accept:
  - Encoded word is pushed with tag = next-address.
  - next-address += 4, wrapping modulo 2^ADDR_W.
  - Latency: word visible on the outputs at the edge after accept (1 cycle).
- Illegal funct3 (3..7):
  - Field set is consumed (handshake completes) but not pushed.
  - Address does not advance.
  - err_pulse=1 for the next cycle only.
- Buffer FSM:
  - EMPTY: in_ready=1, out_valid=0. Legal accept -> ONE.
  - ONE: in_ready=1, out_valid=1. Legal accept with no pop -> TWO. Pop with no accept -> EMPTY. Simultaneous accept+pop -> stays ONE, head replaced by new word.
  - TWO: in_ready=0, out_valid=1. Pop -> ONE, second entry moves to head.
- Output hold: instr_word/instr_addr stable while out_valid && !out_ready.
- Output when empty: holds last popped values; out_valid=0.
- Pop: out_valid && out_ready. Each pop increments word_count, saturating at 16'hFFFF.
- in_ready is combinational from state only, never from in_valid/out_ready (no comb path input->output).
- flush, next edge:
  - Buffer -> EMPTY, out_valid=0.
  - next-address=BASE_ADDR.
  - word_count unchanged.
  - Any same-cycle input accept is discarded.
  - flush has priority over accept and pop.
- Reset mid-transfer: buffered words lost; no partial output.

Optional Feature:
- Macro: S_ENC_RANGE_CHECK_EN.
- Defined: offset must satisfy -2048 <= offset <= 2047, i.e. offset[31:11] all equal. Out-of-range offset is treated like illegal funct3: consumed, not pushed, err_pulse for one cycle, address unchanged.
- Undefined: no check; offset silently truncated to offset[11:0].

Test Plan:
- Basic encode: reset, offset=8, rs2=5, rs1=2, funct3=2, out_ready=1 -> one cycle later out_valid=1, instr_word=32'h00512423, instr_addr=0; word_count=1 after pop.
- Negative offset: offset=-1, rs2=1, rs1=3, funct3=0 -> instr_word=32'hFE118FA3; next legal word tagged addr 4.
- Backpressure: out_ready=0, three back-to-back valid inputs -> in_ready drops after 2nd accept; 3rd held. Raise out_ready -> words emerge in order at addr 0,4,8; no loss or duplication.
- Illegal funct3=3 between two SW inputs -> err_pulse one cycle; emitted addrs 0 and 4 (no gap); word_count=2.
- Flush with 2 buffered words plus an input accepted the same cycle -> out_valid=0 next cycle; next legal word tagged BASE_ADDR.
- With S_ENC_RANGE_CHECK_EN, offset=2048 -> dropped, err_pulse=1. Without it -> encoded with imm=12'h800, instr[31:25]=7'h40.
